rtc_settable_clock: RTL and testbench

- Parametrised successor to the board's free-running 24 h clock.
- Single clock domain: a clock-enable tick derived from CLOCK_50 replaces the derived 1 Hz clock.
- Adds user time-set FSM (mode/inc buttons), blinking of the field being edited, and a runtime 12/24 h display format.
- Drives six active-low 7-segment digits: HEX5..HEX0 = hh:mm:ss.

---
 rtl/rtc_settable_clock.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_rtc_settable_clock.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_settable_clock.sv
// rtc_settable_clock - settable 24 h real-time clock with six 7-segment digits.
//
// A divider on CLOCK_50 produces a one-cycle sec_tick. In RUN the time counts
// up on every tick. The mode button steps through the set states
// RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN, and the inc button changes the
// field being edited. The edited field blinks. fmt_12h chooses 12 h or 24 h
// display. Time is always stored as 24 h.
//
// Parameters:
//   CLK_FREQ_HZ  clock cycles per second; this is the sec_tick period
//   BLINK_HALF   clock cycles in each visible/blank half of the blink
//
// Ports:
//   CLOCK_50            system clock
//   rst                 synchronous active-high reset
//   mode_btn, inc_btn   debounced synchronous levels; rising edges are detected here
//   fmt_12h             1 = 12 h display, 0 = 24 h display
//   HEX0..HEX5          active-low {g,f,e,d,c,b,a}: ss, mm, hh (ones digit first)
//   pm                  12 h mode and hour >= 12
//   sec_tick            one-cycle pulse each time the divider wraps
//   setting             high while in any set state
//
// Optional build macro RTC_ALARM_EN adds the ports alarm_arm, alarm_ack and
// alarm_out, and adds the states SET_AL_HR and SET_AL_MIN after SET_SEC.
//
// Handshake: there is none. Buttons are levels. An action occurs only on a
// 0->1 change seen between two consecutive clock edges. All outputs are
// registered, so they show the internal state one cycle later.
module rtc_settable_clock #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BLINK_HALF  = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       fmt_12h,
`ifdef RTC_ALARM_EN
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic       alarm_out,
`endif
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       pm,
    output logic       sec_tick,
    output logic       setting
);
    localparam int DIV_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ_HZ - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [2:0] {
        S_RUN,
        S_SET_HR,
        S_SET_MIN,
        S_SET_SEC
`ifdef RTC_ALARM_EN
        ,
        S_SET_AL_HR,
        S_SET_AL_MIN
`endif
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_off;
    logic             mode_q, inc_q, mode_rise, inc_rise, tick, div_clr;
    logic [5:0]       sec_r, min_r, sec_n, min_n;
    logic [4:0]       hour_r, hour_n;
    logic [4:0]       show_hr;
    logic [5:0]       show_min, hr_disp;
    logic             blank_hr, blank_min, blank_sec;
    logic [6:0]       h0_n, h1_n, h2_n, h3_n, h4_n, h5_n;
    logic             pm_n;

    function automatic logic [5:0] wrap59(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] wrap23(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_OFF;
        endcase
    endfunction

    assign mode_rise = mode_btn & ~mode_q;
    assign inc_rise  = inc_btn & ~inc_q;
    assign tick      = (div_cnt == DIV_LAST);

`ifdef RTC_ALARM_EN
    logic [4:0] al_hr, al_hr_n;
    logic [5:0] al_min, al_min_n, al_secs;
    logic       al_hit;
`endif

    // Next-state logic. A mode edge takes priority over an inc edge in the
    // same cycle. In RUN, a tick and a mode edge in the same cycle both apply.
    always_comb begin
        state_n = state;
        sec_n   = sec_r;
        min_n   = min_r;
        hour_n  = hour_r;
        div_clr = 1'b0;
`ifdef RTC_ALARM_EN
        al_hr_n  = al_hr;
        al_min_n = al_min;
`endif
        case (state)
            S_RUN: begin
                if (tick) begin
                    sec_n = wrap59(sec_r);
                    if (sec_r == 6'd59) begin
                        min_n = wrap59(min_r);
                        if (min_r == 6'd59) hour_n = wrap23(hour_r);
                    end
                end
                if (mode_rise) state_n = S_SET_HR;
            end
            S_SET_HR: begin
                if (mode_rise)     state_n = S_SET_MIN;
                else if (inc_rise) hour_n  = wrap23(hour_r);
            end
            S_SET_MIN: begin
                if (mode_rise)     state_n = S_SET_SEC;
                else if (inc_rise) min_n   = wrap59(min_r);
            end
            S_SET_SEC: begin
                if (mode_rise) begin
`ifdef RTC_ALARM_EN
                    state_n = S_SET_AL_HR;
`else
                    state_n = S_RUN;
                    div_clr = 1'b1;  // makes the first second after setting a full second
`endif
                end else if (inc_rise) begin
                    sec_n = 6'd0;
                end
            end
`ifdef RTC_ALARM_EN
            S_SET_AL_HR: begin
                if (mode_rise)     state_n = S_SET_AL_MIN;
                else if (inc_rise) al_hr_n = wrap23(al_hr);
            end
            S_SET_AL_MIN: begin
                if (mode_rise) begin
                    state_n = S_RUN;
                    div_clr = 1'b1;
                end else if (inc_rise) begin
                    al_min_n = wrap59(al_min);
                end
            end
`endif
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state   <= S_RUN;
            sec_r   <= 6'd0;
            min_r   <= 6'd0;
            hour_r  <= 5'd0;
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
            div_cnt <= '0;
        end else begin
            state   <= state_n;
            sec_r   <= sec_n;
            min_r   <= min_n;
            hour_r  <= hour_n;
            mode_q  <= mode_btn;
            inc_q   <= inc_btn;
            div_cnt <= (div_clr || tick) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // The blink counter is held clear in RUN. Every entry to SET_HR comes from
    // RUN, so each entry starts with the visible half.
    always_ff @(posedge CLOCK_50) begin
        if (rst || state == S_RUN) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

`ifdef RTC_ALARM_EN
    assign al_hit = (state == S_RUN) && tick && (hour_n == al_hr) &&
                    (min_n == al_min) && (sec_n == 6'd0);

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            al_hr     <= 5'd0;
            al_min    <= 6'd0;
            al_secs   <= 6'd0;
            alarm_out <= 1'b0;
        end else begin
            al_hr  <= al_hr_n;
            al_min <= al_min_n;
            if (alarm_ack || !alarm_arm) begin
                alarm_out <= 1'b0;
                al_secs   <= 6'd0;
            end else if (al_hit) begin
                alarm_out <= 1'b1;
                al_secs   <= 6'd0;
            end else if (alarm_out && tick) begin
                // The 60th tick after the alarm sets turns it off.
                if (al_secs == 6'd59) alarm_out <= 1'b0;
                al_secs <= al_secs + 6'd1;
            end
        end
    end
`endif

    // Display values are computed from the current state. They are registered below.
    always_comb begin
        show_hr   = hour_r;
        show_min  = min_r;
        blank_hr  = blink_off && (state == S_SET_HR);
        blank_min = blink_off && (state == S_SET_MIN);
        blank_sec = blink_off && (state == S_SET_SEC);
`ifdef RTC_ALARM_EN
        if (state == S_SET_AL_HR || state == S_SET_AL_MIN) begin
            show_hr   = al_hr;
            show_min  = al_min;
            blank_hr  = blink_off && (state == S_SET_AL_HR);
            blank_min = blink_off && (state == S_SET_AL_MIN);
            blank_sec = 1'b1;
        end
`endif
        if (fmt_12h && show_hr == 5'd0)      hr_disp = 6'd12;
        else if (fmt_12h && show_hr > 5'd12) hr_disp = {1'b0, show_hr} - 6'd12;
        else                                 hr_disp = {1'b0, show_hr};

        h5_n = (fmt_12h && tens_of(hr_disp) == 4'd0) ? SEG_OFF : seg7(tens_of(hr_disp));
        h4_n = seg7(ones_of(hr_disp));
        h3_n = seg7(tens_of(show_min));
        h2_n = seg7(ones_of(show_min));
        h1_n = seg7(tens_of(sec_r));
        h0_n = seg7(ones_of(sec_r));
        pm_n = fmt_12h && (show_hr >= 5'd12);

        if (blank_hr) begin
            h5_n = SEG_OFF;
            h4_n = SEG_OFF;
        end
        if (blank_min) begin
            h3_n = SEG_OFF;
            h2_n = SEG_OFF;
        end
        if (blank_sec) begin
            h1_n = SEG_OFF;
            h0_n = SEG_OFF;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            HEX0     <= SEG_ZERO;
            HEX1     <= SEG_ZERO;
            HEX2     <= SEG_ZERO;
            HEX3     <= SEG_ZERO;
            HEX4     <= SEG_ZERO;
            HEX5     <= SEG_ZERO;
            pm       <= 1'b0;
            sec_tick <= 1'b0;
            setting  <= 1'b0;
        end else begin
            HEX0     <= h0_n;
            HEX1     <= h1_n;
            HEX2     <= h2_n;
            HEX3     <= h3_n;
            HEX4     <= h4_n;
            HEX5     <= h5_n;
            pm       <= pm_n;
            sec_tick <= tick;
            setting  <= (state != S_RUN);
        end
    end
endmodule

// File: tb/tb_rtc_settable_clock.sv
// tb_rtc_settable_clock - self-checking bench for rtc_settable_clock.
// It uses CLK_FREQ_HZ=10 and BLINK_HALF=4. On every posedge, a time-of-day
// model predicts the next registered output word and queues it. At each
// negedge, a compare process pops that word and checks it against the DUT.
// Directed sections check literal values that pin the model itself.
`timescale 1ns/1ps
module tb_rtc_settable_clock;
    localparam int CLK_HZ = 10;
    localparam int BLINK  = 4;
    localparam int W      = 45;
    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                           D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                           D6 = 7'b0000010, D7 = 7'b1111000, D8 = 7'b0000000,
                           D9 = 7'b0010000;
    localparam logic [6:0] SEG_TAB [10] = '{D0, D1, D2, D3, D4, D5, D6, D7, D8, D9};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       fmt_12h = 1'b0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       pm, sec_tick, setting;

    rtc_settable_clock #(.CLK_FREQ_HZ(CLK_HZ), .BLINK_HALF(BLINK)) dut (
        .CLOCK_50(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .fmt_12h(fmt_12h), .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
        .HEX4(hex4), .HEX5(hex5), .pm(pm), .sec_tick(sec_tick), .setting(setting)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    bit m_known = 0;
    int m_tod;     // seconds since midnight
    int m_mode;    // 0 run, 1 hour, 2 minute, 3 second
    int m_div;     // cycles into the current second
    int m_age;     // cycles spent in set states since leaving run
    bit m_mode_q, m_inc_q;

    function automatic logic [6:0] digit_seg(input int d);
        if (d >= 0 && d <= 9) return SEG_TAB[d];
        return OFF;
    endfunction

    function automatic logic [W-1:0] predict(input int tod, input int mode, input int age,
                                             input bit fmt, input bit tk);
        int hh, mm, ss, hd;
        logic [6:0] d [6];
        hh = tod / 3600;
        mm = (tod / 60) % 60;
        ss = tod % 60;
        hd = hh;
        if (fmt) hd = (hh % 12 == 0) ? 12 : hh % 12;
        d[5] = (fmt && hd < 10) ? OFF : digit_seg(hd / 10);
        d[4] = digit_seg(hd % 10);
        d[3] = digit_seg(mm / 10);
        d[2] = digit_seg(mm % 10);
        d[1] = digit_seg(ss / 10);
        d[0] = digit_seg(ss % 10);
        if (mode != 0 && ((age / BLINK) % 2) == 1) begin
            d[2 * (3 - mode) + 1] = OFF;
            d[2 * (3 - mode)]     = OFF;
        end
        return {d[5], d[4], d[3], d[2], d[1], d[0], (fmt && hh >= 12), tk, (mode != 0)};
    endfunction

    always @(posedge clk) begin
        bit me, ie, tk;
        int hh, mm, ss;
        if (rst) begin
            m_known = 1; m_tod = 0; m_mode = 0; m_div = 0; m_age = 0;
            m_mode_q = 0; m_inc_q = 0;
            exp_q.push_back({D0, D0, D0, D0, D0, D0, 3'b000});
        end else if (m_known) begin
            tk = (m_div == CLK_HZ - 1);
            exp_q.push_back(predict(m_tod, m_mode, m_age, fmt_12h, tk));
            me = mode_btn && !m_mode_q;
            ie = inc_btn && !m_inc_q;
            hh = m_tod / 3600;
            mm = (m_tod / 60) % 60;
            ss = m_tod % 60;
            if (m_mode == 0) begin
                if (tk) m_tod = (m_tod + 1) % 86400;
            end else if (!me && ie) begin
                case (m_mode)
                    1:       m_tod = ((hh + 1) % 24) * 3600 + mm * 60 + ss;
                    2:       m_tod = hh * 3600 + ((mm + 1) % 60) * 60 + ss;
                    default: m_tod = hh * 3600 + mm * 60;
                endcase
            end
            m_age = (m_mode == 0) ? 0 : m_age + 1;
            m_div = tk ? 0 : m_div + 1;
            if (me) begin
                if (m_mode == 3) m_div = 0;
                m_mode = (m_mode + 1) % 4;
            end
            m_mode_q = mode_btn;
            m_inc_q  = inc_btn;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {hex5, hex4, hex3, hex2, hex1, hex0, pm, sec_tick, setting};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t actual=%h expected=%h", $time, a, e);
            end
        end
    end

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            inc_btn = 1'b1;
            @(negedge clk);
            inc_btn = 1'b0;
            @(negedge clk);
        end
    endtask

    function automatic logic [41:0] hexes();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [6:0] prev;
        bit found;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        check("reset_hex", hexes(), {D0, D0, D0, D0, D0, D0});
        check("reset_flags", {39'd0, pm, sec_tick, setting}, 42'd0);

        // First tick happens ten cycles after reset; the display shows it one cycle later.
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("first_tick", {41'd0, sec_tick}, (i == 10) ? 42'd1 : 42'd0);
        end
        @(negedge clk);
        check("hex0_one", {35'd0, hex0}, {35'd0, D1});
        check("tick_one_cycle", {41'd0, sec_tick}, 42'd0);

        // Set the time to 23:59:00, then let it run through midnight.
        press_mode(); press_inc(23);
        press_mode(); press_inc(59);
        press_mode(); press_inc(1);
        press_mode();
        check("set_2359", hexes(), {D2, D3, D5, D9, D0, D0});
        check("setting_low", {41'd0, setting}, 42'd0);
        cycles(580);
        check("at_235958", hexes(), {D2, D3, D5, D9, D5, D8});
        cycles(10);
        check("at_235959", hexes(), {D2, D3, D5, D9, D5, D9});
        cycles(10);
        check("midnight", hexes(), {D0, D0, D0, D0, D0, D0});

        // Hour wraps at the 24th press; 25 presses give 01. 61 minute presses give 01.
        press_mode(); press_inc(25);
        press_mode();
        check("hour_wrap_01", {28'd0, hex5, hex4}, {28'd0, D0, D1});
        check("setting_high", {41'd0, setting}, 42'd1);
        press_inc(61);
        press_mode(); press_mode();
        check("after_set_0101", {14'd0, hex5, hex4, hex3, hex2}, {14'd0, D0, D1, D0, D1});

        // 12 h format: 13 h is shown as " 1" with pm set.
        press_mode(); press_inc(12); press_mode();
        fmt_12h = 1'b1;
        cycles(2);
        check("h13_12h", {28'd0, hex5, hex4}, {28'd0, OFF, D1});
        check("pm_13", {41'd0, pm}, 42'd1);
        press_mode(); press_mode(); press_mode();
        press_inc(11); press_mode();
        cycles(1);
        check("h00_12h", {28'd0, hex5, hex4}, {28'd0, D1, D2});
        check("pm_00", {41'd0, pm}, 42'd0);
        fmt_12h = 1'b0;
        cycles(2);
        check("h00_24h", {28'd0, hex5, hex4}, {28'd0, D0, D0});

        // Blink in SET_MIN: 4 cycles blank, then 4 cycles visible; the hour stays steady.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            prev = hex3;
            @(negedge clk);
            if (prev != OFF && hex3 == OFF) found = 1;
        end
        check("blink_seen", {41'd0, found}, 42'd1);
        if (found) begin
            for (int i = 0; i < 8; i++) begin
                check("blink_hex3", {35'd0, hex3}, {35'd0, (i < 4) ? OFF : D0});
                check("blink_hour_steady", {28'd0, hex5, hex4}, {28'd0, D0, D0});
                @(negedge clk);
            end
        end

        // Reset in SET_SEC, with mode and inc edges arriving in the same cycle.
        press_mode();
        rst = 1'b1; mode_btn = 1'b1; inc_btn = 1'b1;
        @(negedge clk);
        rst = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        check("rst_set_hex", hexes(), {D0, D0, D0, D0, D0, D0});
        check("rst_set_flags", {39'd0, pm, sec_tick, setting}, 42'd0);
        @(negedge clk);
        check("rst_set_run", {41'd0, setting}, 42'd0);
        check("rst_set_zero", hexes(), {D0, D0, D0, D0, D0, D0});

        // Random button, format and reset activity, checked against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0)   mode_btn = ~mode_btn;
            if ($urandom_range(0, 3) == 0)   inc_btn  = ~inc_btn;
            if ($urandom_range(0, 49) == 0)  fmt_12h  = ~fmt_12h;
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        cycles(2);
        report();
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        n_fail++;
        report();
        $fatal(1, "watchdog expired");
    end
endmodule
